toaplan2_cen_gen: RTL

//  Multi-channel fractional-N clock-enable generator, successor to the fixed per-game CEN dividers.

---
 rtl/toaplan2_cen_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/toaplan2_cen_gen.sv
// Fractional-N CEN/CENB generator: NCH channels at CLK*NUM/DEN with glitch-free run-time retuning; `CEN_PAUSE_EN adds a masked freeze.
// Latency: pulses registered 1 cycle after detection; no backpressure, every config write is either accepted or flagged on CFG_ERR.
module toaplan2_cen_gen #(
  parameter int                  NCH        = 8,
  parameter int                  NW         = 10,
  parameter logic [NCH*NW-1:0]   NUM_INIT   = {NCH{10'd1}},
  parameter logic [NCH*NW-1:0]   DEN_INIT   = {NCH{10'd12}},
  parameter logic [NCH-1:0]      PAUSE_MASK = {NCH{1'b0}}
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CFG_WE,
  input  logic [$clog2(NCH)-1:0] CFG_CH,
  input  logic [NW-1:0]          CFG_NUM,
  input  logic [NW-1:0]          CFG_DEN,
  output logic                   CFG_ERR,
  output logic [NCH-1:0]         CFG_PEND,
  input  logic                   PAUSE,
  output logic [NCH-1:0]         CEN,
  output logic [NCH-1:0]         CENB
);

  localparam int CHW = $clog2(NCH);

  logic [NW:0] num_x2;
  logic        wr_legal;
  logic        err_q;

  // 2*NUM <= DEN keeps CEN and CENB in separate cycles and acc within NW bits.
  assign num_x2   = {CFG_NUM, 1'b0};
  assign wr_legal = (CFG_DEN != '0) && (num_x2 <= {1'b0, CFG_DEN}) && (32'(CFG_CH) < NCH);

  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= CFG_WE && !wr_legal;
  end

  assign CFG_ERR = err_q;

`ifndef CEN_PAUSE_EN
  logic unused_pause;
  assign unused_pause = PAUSE ^ (^PAUSE_MASK);
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CHW-1:0] CH_ID = CHW'(i);

    logic [NW-1:0] acc_q, num_q, den_q, num_sh, den_sh;
    logic          pend_q, cen_q, cenb_q;
    logic [NW:0]   sum;
    logic [NW-1:0] half;
    logic          hit, hit_b, frz, apply, wr_me;

    assign sum   = {1'b0, acc_q} + {1'b0, num_q};
    assign half  = den_q >> 1;
    assign hit   = sum >= {1'b0, den_q};
    assign hit_b = (acc_q < half) && (sum >= {1'b0, half});
    assign wr_me = CFG_WE && wr_legal && (CFG_CH == CH_ID);

`ifdef CEN_PAUSE_EN
    assign frz = PAUSE && PAUSE_MASK[i];
`else
    assign frz = 1'b0;
`endif

    // Swap on the CEN edge so the new rate starts at a clean phase; an idle channel swaps at once.
    assign apply = pend_q && !frz && (hit || (num_q == '0));

    always_ff @(posedge CLK) begin
      if (RESET) begin
        acc_q  <= '0;
        num_q  <= NUM_INIT[i*NW +: NW];
        den_q  <= DEN_INIT[i*NW +: NW];
        num_sh <= '0;
        den_sh <= '0;
        pend_q <= 1'b0;
        cen_q  <= 1'b0;
        cenb_q <= 1'b0;
      end else begin
        if (frz) begin
          cen_q  <= 1'b0;
          cenb_q <= 1'b0;
        end else begin
          cen_q  <= hit;
          cenb_q <= hit_b;
          if (apply) begin
            acc_q  <= '0;
            num_q  <= num_sh;
            den_q  <= den_sh;
            pend_q <= 1'b0;
          end else if (hit) begin
            // Wraps modulo 2^NW; the true result is below DEN so truncation is exact.
            acc_q <= sum[NW-1:0] - den_q;
          end else begin
            acc_q <= sum[NW-1:0];
          end
        end
        // Placed after the apply so a same-cycle write lands in the shadow and stays pending.
        if (wr_me) begin
          num_sh <= CFG_NUM;
          den_sh <= CFG_DEN;
          pend_q <= 1'b1;
        end
      end
    end

    assign CEN[i]      = cen_q;
    assign CENB[i]     = cenb_q;
    assign CFG_PEND[i] = pend_q;
  end

endmodule
